// File: rtl/fetch_unit.sv
// fetch_unit -- single-outstanding instruction fetch engine.
//
// Accepts a fetch address from the PC register, issues one memory request,
// waits for the response and holds the fetched instruction until decode
// takes it. A redirect flushes the in-flight fetch or the held instruction.
// A response that arrives after a redirect is discarded.
//
// Optional feature (macro FETCH_MISALIGN_CHECK_EN):
//   defined   - a pc_i with bits [1:0] != 0 issues no memory request. It
//               produces a faulting instruction (inst_fault_o=1, inst_o=0,
//               inst_pc_o=pc_i).
//   undefined - mem_addr_o[1:0] is forced to 0 and inst_fault_o is tied 0.
//
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-low reset
//   pc_i          fetch address
//   pc_valid_i    pc_i valid
//   pc_ready_o    fetch_unit accepts pc_i (high only in IDLE)
//   redirect_i    flush in-flight fetch / held instruction
//   mem_req_o     memory request
//   mem_addr_o    request address
//   mem_gnt_i     request accepted
//   mem_rvalid_i  response data valid
//   mem_rdata_i   response data
//   inst_valid_o  instruction valid to decode
//   inst_o        instruction word
//   inst_pc_o     address of inst_o
//   inst_ready_i  decode accepts instruction
//   inst_fault_o  misaligned-fetch fault, qualified by inst_valid_o
module fetch_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              pc_valid_i,
  output logic              pc_ready_o,
  input  logic              redirect_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              inst_valid_o,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  input  logic              inst_ready_i,
  output logic              inst_fault_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_drop;
  logic              w_drop_next;
  logic              w_ld_addr;
  logic              w_ld_inst;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_inst;
  logic [ADDR_W-1:0] r_inst_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic              w_ld_fault;
  logic              r_fault;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_drop  <= w_drop_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_drop_next = r_drop;
    w_ld_addr   = 1'b0;
    w_ld_inst   = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    w_ld_fault  = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (pc_valid_i && !redirect_i) begin
`ifdef FETCH_MISALIGN_CHECK_EN
          if (pc_i[1:0] != 2'b00) begin
            // Misaligned: skip memory entirely and present a faulting slot.
            w_next     = S_HOLD;
            w_ld_fault = 1'b1;
          end else begin
            w_next    = S_REQ;
            w_ld_addr = 1'b1;
          end
`else
          w_next    = S_REQ;
          w_ld_addr = 1'b1;
`endif
        end
      end
      S_REQ: begin
        if (mem_gnt_i) begin
          // Once granted, a response is owed; a simultaneous redirect must
          // wait for it and throw it away.
          w_next = S_WAIT;
          if (redirect_i) w_drop_next = 1'b1;
        end else if (redirect_i) begin
          w_next = S_IDLE;
        end
      end
      S_WAIT: begin
        if (mem_rvalid_i) begin
          w_drop_next = 1'b0;
          if (r_drop || redirect_i) begin
            w_next = S_IDLE;
          end else begin
            w_next    = S_HOLD;
            w_ld_inst = 1'b1;
          end
        end else if (redirect_i) begin
          w_drop_next = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_i || inst_ready_i) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath registers; the address register only loads on a real request
  // so mem_addr_o keeps its last value outside REQ.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr    <= '0;
      r_inst    <= '0;
      r_inst_pc <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      r_fault   <= 1'b0;
`endif
    end else begin
      if (w_ld_addr) r_addr <= pc_i;
      if (w_ld_inst) begin
        r_inst    <= mem_rdata_i;
        r_inst_pc <= r_addr;
`ifdef FETCH_MISALIGN_CHECK_EN
        r_fault   <= 1'b0;
`endif
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      if (w_ld_fault) begin
        r_inst    <= '0;
        r_inst_pc <= pc_i;
        r_fault   <= 1'b1;
      end
`endif
    end
  end

  assign pc_ready_o   = (r_state == S_IDLE);
  assign mem_req_o    = (r_state == S_REQ);
  assign inst_valid_o = (r_state == S_HOLD);
  assign inst_o       = r_inst;
  assign inst_pc_o    = r_inst_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign mem_addr_o   = r_addr;
  assign inst_fault_o = r_fault;
`else
  assign mem_addr_o   = {r_addr[ADDR_W-1:2], 2'b00};
  assign inst_fault_o = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        pc_valid_i;
  logic        pc_ready_o;
  logic        redirect_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_ready_i;
  logic        inst_fault_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
    logic        fault;
  } exp_t;
  exp_t sb[$];

  fetch_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_i         (pc_i),
    .pc_valid_i   (pc_valid_i),
    .pc_ready_o   (pc_ready_o),
    .redirect_i   (redirect_i),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .inst_pc_o    (inst_pc_o),
    .inst_ready_i (inst_ready_i),
    .inst_fault_o (inst_fault_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a presented instruction and compare it with the
  // oldest scoreboard entry.
  task automatic get_inst(input string tag, input int budget);
    exp_t e;
    int n;
    n = 0;
    while (inst_valid_o !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 32'(inst_valid_o), 32'd1);
    if (inst_valid_o === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $error("FAIL %s_sb: observed=unexpected_inst expected=empty", tag);
      end else begin
        e = sb.pop_front();
        chk({tag, "_inst"},  inst_o,               e.data);
        chk({tag, "_pc"},    inst_pc_o,            e.pc);
        chk({tag, "_fault"}, 32'(inst_fault_o),    32'(e.fault));
      end
    end
  endtask

  // Accept addr, immediate grant, response one cycle later; ends in HOLD.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] data);
    pc_i = addr; pc_valid_i = 1'b1;
    tick();
    pc_valid_i = 1'b0; mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = data;
    sb.push_back('{data: data, pc: addr, fault: 1'b0});
    tick();
    mem_rvalid_i = 1'b0;
  endtask

  initial begin
    rst = 1'b0; pc_i = '0; pc_valid_i = 1'b0; redirect_i = 1'b0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; inst_ready_i = 1'b1;

    // reset values
    #2;
    chk("rst_pc_ready",  32'(pc_ready_o),   32'd1);
    chk("rst_mem_req",   32'(mem_req_o),    32'd0);
    chk("rst_inst_vld",  32'(inst_valid_o), 32'd0);
    chk("rst_fault",     32'(inst_fault_o), 32'd0);
    chk("rst_mem_addr",  mem_addr_o,        32'h0);
    chk("rst_inst",      inst_o,            32'h0);
    chk("rst_inst_pc",   inst_pc_o,         32'h0);
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("post_rst_ready", 32'(pc_ready_o), 32'd1);

    // stray rvalid in IDLE is ignored
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFEF00D;
    tick();
    mem_rvalid_i = 1'b0;
    chk("idle_rvalid_vld",   32'(inst_valid_o), 32'd0);
    chk("idle_rvalid_ready", 32'(pc_ready_o),   32'd1);

    // basic fetch with minimum latency
    pc_i = 32'h100; pc_valid_i = 1'b1;
    tick();
    pc_valid_i = 1'b0;
    chk("basic_req",   32'(mem_req_o),  32'd1);
    chk("basic_addr",  mem_addr_o,      32'h100);
    chk("basic_busy",  32'(pc_ready_o), 32'd0);
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    chk("basic_req_off",   32'(mem_req_o),    32'd0);
    chk("basic_addr_hold", mem_addr_o,        32'h100);
    chk("basic_no_vld_n2", 32'(inst_valid_o), 32'd0);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h00500093;
    sb.push_back('{data: 32'h00500093, pc: 32'h100, fault: 1'b0});
    tick();
    mem_rvalid_i = 1'b0;
    get_inst("basic", 0);
    tick();
    chk("basic_done_vld",   32'(inst_valid_o), 32'd0);
    chk("basic_done_ready", 32'(pc_ready_o),   32'd1);

    // backpressure for 5 cycles
    inst_ready_i = 1'b0;
    fetch(32'h200, 32'h11111111);
    get_inst("bp", 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_vld",  32'(inst_valid_o), 32'd1);
      chk("bp_hold_inst", inst_o,            32'h11111111);
      chk("bp_hold_rdy",  32'(pc_ready_o),   32'd0);
    end
    inst_ready_i = 1'b1;
    tick();
    chk("bp_release_vld", 32'(inst_valid_o), 32'd0);
    chk("bp_release_rdy", 32'(pc_ready_o),   32'd1);

    // redirect in WAIT before rvalid
    pc_i = 32'h300; pc_valid_i = 1'b1;
    tick();
    pc_valid_i = 1'b0; mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0; redirect_i = 1'b1;
    tick();
    redirect_i = 1'b0;
    chk("rdw_still_busy", 32'(pc_ready_o), 32'd0);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
    tick();
    mem_rvalid_i = 1'b0;
    chk("rdw_no_vld", 32'(inst_valid_o), 32'd0);
    chk("rdw_ready",  32'(pc_ready_o),   32'd1);
    tick();
    chk("rdw_no_vld2", 32'(inst_valid_o), 32'd0);

    // grant stall then redirect during the stall
    pc_i = 32'h400; pc_valid_i = 1'b1;
    tick();
    pc_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_req",  32'(mem_req_o), 32'd1);
      chk("stall_addr", mem_addr_o,     32'h400);
      tick();
    end
    redirect_i = 1'b1;
    tick();
    redirect_i = 1'b0;
    chk("stall_rd_req",   32'(mem_req_o),  32'd0);
    chk("stall_rd_ready", 32'(pc_ready_o), 32'd1);

    // stalled grant and late response still deliver
    pc_i = 32'h404; pc_valid_i = 1'b1;
    tick();
    pc_valid_i = 1'b0;
    tick(); tick();
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    tick();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h22222222;
    sb.push_back('{data: 32'h22222222, pc: 32'h404, fault: 1'b0});
    tick();
    mem_rvalid_i = 1'b0;
    get_inst("late", 4);
    tick();

    // simultaneous grant and redirect: response dropped
    pc_i = 32'h600; pc_valid_i = 1'b1;
    tick();
    pc_valid_i = 1'b0; mem_gnt_i = 1'b1; redirect_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0; redirect_i = 1'b0;
    chk("gr_wait_busy", 32'(pc_ready_o), 32'd0);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h33333333;
    tick();
    mem_rvalid_i = 1'b0;
    chk("gr_no_vld", 32'(inst_valid_o), 32'd0);
    chk("gr_ready",  32'(pc_ready_o),   32'd1);

    // redirect in HOLD wins over inst_ready
    fetch(32'h500, 32'h44444444);
    get_inst("hold_rd", 0);
    redirect_i = 1'b1; inst_ready_i = 1'b1;
    tick();
    redirect_i = 1'b0;
    chk("hold_rd_vld",   32'(inst_valid_o), 32'd0);
    chk("hold_rd_ready", 32'(pc_ready_o),   32'd1);

    // misaligned fetch address
    pc_i = 32'h102; pc_valid_i = 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
    sb.push_back('{data: 32'h0, pc: 32'h102, fault: 1'b1});
    tick();
    pc_valid_i = 1'b0;
    chk("mis_no_req", 32'(mem_req_o), 32'd0);
    get_inst("mis", 0);
    tick();
    chk("mis_done_ready", 32'(pc_ready_o), 32'd1);
`else
    tick();
    pc_valid_i = 1'b0;
    chk("mis_req",   32'(mem_req_o),    32'd1);
    chk("mis_addr",  mem_addr_o,        32'h100);
    chk("mis_fault", 32'(inst_fault_o), 32'd0);
    redirect_i = 1'b1;
    tick();
    redirect_i = 1'b0;
    chk("mis_rd_req",   32'(mem_req_o),  32'd0);
    chk("mis_rd_ready", 32'(pc_ready_o), 32'd1);
`endif

    // reset asserted in WAIT, stray response afterwards
    pc_i = 32'h700; pc_valid_i = 1'b1;
    tick();
    pc_valid_i = 1'b0; mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    rst = 1'b0;
    #1;
    chk("rw_pc_ready", 32'(pc_ready_o),   32'd1);
    chk("rw_mem_req",  32'(mem_req_o),    32'd0);
    chk("rw_inst_vld", 32'(inst_valid_o), 32'd0);
    chk("rw_mem_addr", mem_addr_o,        32'h0);
    chk("rw_inst",     inst_o,            32'h0);
    chk("rw_inst_pc",  inst_pc_o,         32'h0);
    chk("rw_fault",    32'(inst_fault_o), 32'd0);
    tick();
    rst = 1'b1;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h55555555;
    tick();
    mem_rvalid_i = 1'b0;
    chk("rw_stray_vld",   32'(inst_valid_o), 32'd0);
    chk("rw_stray_ready", 32'(pc_ready_o),   32'd1);
    chk("rw_stray_inst",  inst_o,            32'h0);

    // normal operation after reset
    fetch(32'h800, 32'h66666666);
    get_inst("after_rst", 0);
    tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameters SHALL be:
- ADDR_W, 32, address width.
- DATA_W, 32, instruction width.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- pc_i  in  32  fetch address from the PC register.
- pc_valid_i  in  1  pc_i valid.
- pc_ready_o  out  1  fetch_unit accepts pc_i.
- redirect_i  in  1  flush: discard in-flight fetch and any held instruction.
- mem_req_o  out  1  memory request.
- mem_addr_o  out  32  request address.
- mem_gnt_i  in  1  request accepted.
- mem_rvalid_i  in  1  response data valid.
- mem_rdata_i  in  32  response data.
- inst_valid_o  out  1  instruction valid to decode.
- inst_o  out  32  instruction word.
- inst_pc_o  out  32  address of inst_o.
- inst_ready_i  in  1  decode accepts instruction.
- inst_fault_o  out  1  misaligned-fetch fault, qualified by inst_valid_o.

Function
REQ-003 The FSM SHALL have four states: IDLE, REQ, WAIT and HOLD, with at most one outstanding memory request.
REQ-004 In IDLE, pc_ready_o SHALL be 1; in all other states it SHALL be 0.
REQ-005 In IDLE, pc_valid_i=1 with redirect_i=0 SHALL latch pc_i into an internal address register and move to REQ.
REQ-006 In REQ, mem_req_o SHALL be 1 and mem_addr_o SHALL equal the latched address.
- mem_gnt_i=1: move to WAIT.
- redirect_i=1: return to IDLE and withdraw the request next cycle.
- Simultaneous gnt and redirect: move to WAIT with drop flag set.
REQ-007 Outside REQ, mem_req_o SHALL be 0 and mem_addr_o SHALL hold its last value.
REQ-008 In WAIT, redirect_i=1 without mem_rvalid_i SHALL set the drop flag and stay in WAIT.
REQ-009 In WAIT, mem_rvalid_i=1 SHALL act as follows:
- drop flag set or redirect_i=1: discard the data, clear the drop flag, move to IDLE.
- Otherwise: register mem_rdata_i into inst_o and the latched address into inst_pc_o, move to HOLD.
REQ-010 In HOLD, inst_valid_o SHALL be 1, and inst_o, inst_pc_o and inst_fault_o SHALL be stable until inst_valid_o & inst_ready_i, which SHALL move to IDLE.
REQ-011 A redirect_i in HOLD SHALL clear inst_valid_o next cycle and move to IDLE, even if inst_ready_i=1 in the same cycle.
REQ-012 Minimum latency SHALL be as follows, giving a throughput of one instruction per 4 cycles minimum:
- pc accepted in cycle N.
- mem_req_o=1 in cycle N+1, with gnt in the same cycle.
- rvalid in cycle N+2.
- inst_valid_o=1 in cycle N+3.
REQ-013 mem_rvalid_i outside WAIT SHALL be ignored.

Reset
REQ-014 While rst=0 the block SHALL be in IDLE with the following values:
- mem_req_o=0, inst_valid_o=0, inst_fault_o=0, drop flag=0.
- mem_addr_o, inst_o, inst_pc_o = 32'h0.
REQ-015 pc_ready_o SHALL be 1 during and after reset.
REQ-016 Reset asserted mid-transaction SHALL abandon it; a later stray mem_rvalid_i SHALL be ignored per REQ-013.

Configuration
REQ-017 Macro FETCH_MISALIGN_CHECK_EN defined: a pc_i with bits [1:0]!=0 accepted in IDLE SHALL issue no memory request and move directly to HOLD with the following outputs:
- inst_fault_o=1.
- inst_o=32'h0.
- inst_pc_o=pc_i.
REQ-018 Macro FETCH_MISALIGN_CHECK_EN undefined: mem_addr_o[1:0] SHALL be forced to 0 and inst_fault_o SHALL be tied 0.

Verification
REQ-019 Basic fetch: pc_i=32'h100 accepted, gnt immediate, rvalid next cycle with 32'h00500093 -> inst_valid_o=1 three cycles after acceptance, inst_o=32'h00500093, inst_pc_o=32'h100.
REQ-020 Backpressure: inst_ready_i=0 for 5 cycles -> inst_valid_o and inst_o held, pc_ready_o=0; on ready -> IDLE next cycle.
REQ-021 Redirect in WAIT: redirect_i pulse before rvalid, then rvalid with 32'hDEADBEEF -> inst_valid_o never asserts, pc_ready_o=1 next cycle.
REQ-022 Grant stall: mem_gnt_i=0 for 3 cycles -> mem_req_o=1 and mem_addr_o stable throughout; redirect in a stall cycle -> mem_req_o=0 next cycle.
REQ-023 Misalign: pc_i=32'h102 with FETCH_MISALIGN_CHECK_EN -> no mem_req_o, inst_fault_o=1, inst_pc_o=32'h102; without the macro -> mem_addr_o=32'h100.
REQ-024 Reset in WAIT: rst low for 1 cycle -> all outputs at reset values, and a following rvalid is ignored.
